seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_det_pkg.sv | 8 +
 rtl/seq_pattern_detector_sat_counter.sv | 18 +
 rtl/seq_pattern_detector.sv | 86 ++++++++
 tb/tb_seq_pattern_detector.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type and legal parameter ranges for seq_pattern_detector
package seq_det_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HUNT} seqdet_state_t;
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;
endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// sat_counter: W-bit up counter that saturates at all-ones, with synchronous clear
// Ports: clk, rst_n (async active-low), clr_i (clear), inc_i (count enable), cnt_o (count)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial PAT_W-bit pattern matcher with Mealy detect pulse and optional match counter
// Ports: clk, rst_n (async active-low), din/din_valid (serial data), pattern/pat_load (load and re-arm),
//        overlap_en (overlapping matches), detect (match pulse), armed (pattern loaded), match_count
// Macro SEQDET_MATCH_COUNT_EN enables the saturating match counter; otherwise match_count is 0.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pat_load,
  input  logic             overlap_en,
  output logic             detect,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);
  localparam int FW = $clog2(PAT_W);
  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_pattern_detector: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_pattern_detector: CNT_W=%0d outside %0d..%0d", CNT_W, CNT_W_MIN, CNT_W_MAX);
  end
  seqdet_state_t    state_q, state_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic [PAT_W-1:0] pat_q, pat_d, shifted;
  // history plus the incoming bit, oldest bit at the MSB to line up with pattern
  assign shifted  = {hist_q, din};
  assign fill_inc = fill_q + 1'b1;
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    detect  = 1'b0;
    if (pat_load) begin
      pat_d   = pattern;
      hist_d  = '0;
      fill_d  = '0;
      state_d = S_FILL;
    end else if (din_valid && state_q == S_FILL) begin
      hist_d  = shifted[PAT_W-2:0];
      fill_d  = fill_inc;
      state_d = (fill_inc == FW'(PAT_W - 1)) ? S_HUNT : S_FILL;
    end else if (din_valid && state_q == S_HUNT) begin
      detect = (shifted == pat_q);
      if (detect && !overlap_en) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = S_FILL;
      end else begin
        hist_d = shifted[PAT_W-2:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
    end
  assign armed = (state_q != S_IDLE);
`ifdef SEQDET_MATCH_COUNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (pat_load),
    .inc_i (detect),
    .cnt_o (match_count)
  );
`else
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: scoreboard bench for seq_pattern_detector across three parameterisations
module tb_seq_pattern_detector;
`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic pat_load = 1'b0;
  logic overlap_en = 1'b1;
  logic [2:0] pat3 = '0;
  logic [3:0] pat4 = '0;
  logic det3, det4, det2, arm3, arm4, arm2;
  logic [7:0] cnt3, cnt4;
  logic [1:0] cnt2;
  int passed = 0;
  int total = 0;
  int sel = 0;
  string cur = "init";
  logic exp_q[$];
  always #5 clk = ~clk;
  seq_pattern_detector #(.PAT_W(3), .CNT_W(8)) d3 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pattern(pat3),
    .pat_load(pat_load), .overlap_en(overlap_en), .detect(det3), .armed(arm3), .match_count(cnt3));
  seq_pattern_detector #(.PAT_W(4), .CNT_W(8)) d4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pattern(pat4),
    .pat_load(pat_load), .overlap_en(overlap_en), .detect(det4), .armed(arm4), .match_count(cnt4));
  seq_pattern_detector #(.PAT_W(3), .CNT_W(2)) d2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pattern(pat3),
    .pat_load(pat_load), .overlap_en(overlap_en), .detect(det2), .armed(arm2), .match_count(cnt2));
  logic det_sel;
  assign det_sel = (sel == 0) ? det3 : (sel == 1) ? det4 : det2;
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      automatic logic e = exp_q.pop_front();
      total++;
      if (det_sel !== e) $display("FAIL %s detect: got %b expected %b at %0t", cur, det_sel, e, $time);
      else passed++;
    end
  task automatic cyc(input logic pl, input logic b, input logic v, input logic e);
    pat_load = pl;
    din = b;
    din_valid = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    din_valid = 1'b0;
  endtask
  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %0d expected %0d", n, got, want);
    else passed++;
  endtask
  task automatic test_reset;
    cur = "reset";
    sel = 0;
    #2;
    chk("reset armed", {7'd0, arm3 | arm4 | arm2}, 8'd0);
    chk("reset count", cnt3 | cnt4 | {6'd0, cnt2}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cur = "idle";
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("idle armed", {7'd0, arm3}, 8'd0);
  endtask
  task automatic test_overlap;
    cur = "overlap";
    sel = 0;
    overlap_en = 1'b1;
    pat3 = 3'b101;
    cyc(1, 0, 0, 0);
    chk("load armed", {7'd0, arm3}, 8'd1);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);
    chk("overlap count", cnt3, CE ? 8'd2 : 8'd0);
  endtask
  task automatic test_non_overlap;
    cur = "non_overlap";
    sel = 0;
    overlap_en = 1'b0;
    pat3 = 3'b101;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("non_overlap count", cnt3, CE ? 8'd1 : 8'd0);
  endtask
  task automatic test_gap;
    cur = "gap";
    sel = 1;
    overlap_en = 1'b1;
    pat4 = 4'b1101;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);
    chk("gap count", cnt4, CE ? 8'd1 : 8'd0);
  endtask
  task automatic test_saturate;
    logic [9:0] s;
    cur = "saturate";
    sel = 2;
    overlap_en = 1'b1;
    pat3 = 3'b101;
    s = 10'b1010101010;
    cyc(1, 0, 0, 0);
    for (int i = 9; i >= 0; i--) cyc(0, s[i], 1, (i <= 7) && (i % 2 == 1));
    chk("saturate count", {6'd0, cnt2}, CE ? 8'd3 : 8'd0);
  endtask
  task automatic test_reload;
    cur = "reload";
    sel = 0;
    overlap_en = 1'b1;
    pat3 = 3'b101;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    pat3 = 3'b011;
    cyc(1, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    chk("reload count", cnt3, CE ? 8'd1 : 8'd0);
  endtask
  task automatic test_midstream_reset;
    cur = "mid_reset";
    sel = 0;
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    din = 1'b1;
    din_valid = 1'b1;
    #1;
    chk("mid_reset armed", {7'd0, arm3}, 8'd0);
    chk("mid_reset count", cnt3, 8'd0);
    chk("mid_reset detect", {7'd0, det3}, 8'd0);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("post_reset armed", {7'd0, arm3}, 8'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_overlap;
    test_non_overlap;
    test_gap;
    test_saturate;
    test_reload;
    test_midstream_reset;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
